mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised modulo-N up/down counter with synchronous load, clock-enable prescaler, terminal-count and wrap indications. It is the general-purpose successor to the fixed 4-bit free-running counter. It serves as the standard timebase and event counter for timers, clock dividers and display scan logic in the FPGA designs. Several instances chain through `wrap` and `en` to form cascaded (BCD / multi-digit) counters.

## Interface
- `WIDTH`, 4, counter width in bits; legal range 1..32.
- `MAX_VAL`, 9, terminal value; the count sequence is 0..MAX_VAL; must satisfy 1 ≤ MAX_VAL ≤ 2^WIDTH−1.
- `DIV`, 1, prescale ratio; the count steps once per DIV enabled cycles; legal range 1..65536.

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable; qualifies prescaler advance.
- `up_dn` input 1: direction; 1 = up, 0 = down.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: value loaded when `load`=1.
- `cnt` output WIDTH: current count (registered).
- `tc` output 1: terminal count (combinational from `cnt`, `up_dn`).
- `wrap` output 1: one-cycle registered pulse on wrap-around.
- `wrap_sticky` output 1: sticky wrap flag; present only with the macro.
- `sticky_clr` input 1: clears `wrap_sticky`; present only with the macro.

## Operation
- Reset values: `cnt`=0, prescaler=0, `wrap`=0, `wrap_sticky`=0. `tc` follows `cnt` (with `cnt`=0, `tc`=1 when `up_dn`=0).
- Priority order per cycle: reset > load > step > hold.
- Load:
  - `cnt` ← min(`load_val`, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - The prescaler clears to 0.
  - `wrap` is 0.
  - Load takes effect regardless of `en`.
- Prescaler:
  - When `en`=1 and no load: if prescaler == DIV−1, then prescaler ← 0 and a step occurs; otherwise prescaler increments.
  - When `en`=0, the prescaler holds.
  - DIV=1 means a step on every enabled cycle, with no prescaler register.
- Step up (`up_dn`=1): if `cnt`==MAX_VAL, then `cnt` ← 0 and `wrap` ← 1; otherwise `cnt`+1.
- Step down (`up_dn`=0): if `cnt`==0, then `cnt` ← MAX_VAL and `wrap` ← 1; otherwise `cnt`−1.
- `cnt` never holds a value > MAX_VAL.
- `tc` = (`up_dn` ? `cnt`==MAX_VAL : `cnt`==0).
- Cascading: the next stage's `en` = `en` & `tc` & prescaler-terminal. For DIV=1 this reduces to `en` & `tc`.
- Direction change mid-count takes effect on the next step only. The prescaler phase is unaffected.
- `wrap` is 0 in every cycle that is not a wrapping step.

## Timing
- Step or load on edge N: the new `cnt` is visible after edge N. `wrap` is high for exactly the cycle after edge N, aligned with the wrapped `cnt`.
- Latency from `en` to `cnt` change: one clock for DIV=1; DIV clocks of continuous `en` for DIV>1.
- `tc` has zero latency relative to `cnt` and `up_dn`.
- Asserting `rst_n` low mid-count forces all registers to reset values immediately, without waiting for `clk`. Deassertion is taken synchronously by the next edge; the integrating design supplies a synchronised release.
- `load` and a would-be wrapping step in the same cycle: load wins and no `wrap` pulse is produced.

## Configuration
- Macro: `MOD_COUNTER_STICKY_EN`.
- Defined:
  - `wrap_sticky` sets on any wrapping step and holds until `sticky_clr`=1.
  - Clear takes effect on the next edge.
  - If set and clear occur in the same cycle, set wins.
  - `wrap_sticky` is unaffected by `load`.
- Undefined: the `wrap_sticky` and `sticky_clr` ports and the register are absent; all other behaviour is identical.

## Structure
- Package `mod_counter_pkg`:
  - constants `DIR_UP`=1'b1 and `DIR_DN`=1'b0;
  - function `clog2` for sizing the prescaler width as clog2(DIV), minimum 1.
- Sub-module `mod_counter_presc`:
  - inputs: `clk`, `rst_n`, `en`, `clr`;
  - output: `tick`;
  - parameter: DIV;
  - generates a bypass (`tick`=`en`) when DIV=1.
- Main-body parameter checks: elaboration-time assertions on the MAX_VAL and DIV ranges.

## Test plan
- Reset mid-count: WIDTH=4, MAX_VAL=9, DIV=1, up, `en`=1 from `cnt`=5; pulse `rst_n` low between edges → `cnt`=0 immediately, `wrap`=0.
- Up wrap: counting from 0 with `en` held → sequence 0..9,0; `wrap`=1 only in the cycle `cnt` reads 0 after 9; `tc`=1 only at 9.
- Down wrap: `up_dn`=0 from `cnt`=1 → 1, 0, 9; `wrap` pulses once with `cnt`=9; `tc`=1 at `cnt`=0.
- Load clamp and priority:
  - `load_val`=13 → `cnt`=9.
  - `load`=1 with `load_val`=0 while `cnt`=9, up and `en`=1 → `cnt`=0, `wrap`=0.
- Prescaler: DIV=3, `en` held → `cnt` advances every 3rd edge. Deasserting `en` for 5 cycles mid-phase resumes at the same phase. `load` resets the phase.
- Sticky (macro defined):
  - two wraps → `wrap_sticky`=1 until `sticky_clr`;
  - `sticky_clr` coinciding with a wrap → `wrap_sticky` stays 1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared direction constants and prescaler sizing helper.
package mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(v)) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mod_counter_presc.sv
// mod_counter_presc: divide-by-DIV enable prescaler; tick marks the terminal phase.
module mod_counter_presc
    import mod_counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    if (DIV == 1) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, clr};
        assign tick = en;
    end else begin : g_div
        localparam int PW = clog2(DIV);
        logic [PW-1:0] ph_q, ph_d;
        logic          term;
        assign term = ph_q == PW'(DIV - 1);
        assign tick = en & term;
        always_comb ph_d = clr ? '0 : !en ? ph_q : term ? '0 : ph_q + PW'(1);
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) ph_q <= '0;
            else        ph_q <= ph_d;
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with load, prescaler, terminal count and wrap pulse.
// Defining MOD_COUNTER_STICKY_EN adds the wrap_sticky flag and its sticky_clr input.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MAX_VAL = 9,
    parameter int     DIV     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_STICKY_EN
    input  logic             sticky_clr,
    output logic             wrap_sticky,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
        $error("mod_counter: WIDTH must be 1..32");
    end
    if (MAX_VAL < 1 || MAX_VAL > (longint'(1) << WIDTH) - 1) begin : g_chk_max
        $error("mod_counter: MAX_VAL must be 1..2^WIDTH-1");
    end
    if (DIV < 1 || DIV > 65536) begin : g_chk_div
        $error("mod_counter: DIV must be 1..65536");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick, at_max, at_zero, wrapping;

    // Load clears the prescaler phase so a reload restarts a full DIV period.
    mod_counter_presc #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    assign at_max   = cnt_q == MAX;
    assign at_zero  = cnt_q == '0;
    assign wrapping = tick & ~load & ((up_dn == DIR_UP) ? at_max : at_zero);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = wrapping;
        if (load)
            cnt_d = (load_val > MAX) ? MAX : load_val;
        else if (tick)
            cnt_d = (up_dn == DIR_UP) ? (at_max ? '0 : cnt_q + WIDTH'(1))
                                      : (at_zero ? MAX : cnt_q - WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign tc   = (up_dn == DIR_UP) ? at_max : at_zero;

`ifdef MOD_COUNTER_STICKY_EN
    logic sticky_q, sticky_d;
    // Set beats a simultaneous clear so no wrap is ever lost.
    always_comb sticky_d = wrapping | (sticky_q & ~sticky_clr);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    assign wrap_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: two counters (DIV=1 and DIV=3) on shared stimulus, checked against a modulo-arithmetic model.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up_dn = 1'b0, load = 1'b0, sticky_clr = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] cnt_a, cnt_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, st_a, st_b;

    int checks = 0;
    int errors = 0;
    int m_cnt[2], m_ph[2], m_wrap[2], m_st[2];
    int div[2] = '{1, 3};
    localparam int MAXV = 9;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_STICKY_EN
        .sticky_clr(sticky_clr), .wrap_sticky(st_a),
`endif
        .cnt(cnt_a), .tc(tc_a), .wrap(wrap_a)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_STICKY_EN
        .sticky_clr(sticky_clr), .wrap_sticky(st_b),
`endif
        .cnt(cnt_b), .tc(tc_b), .wrap(wrap_b)
    );

`ifndef MOD_COUNTER_STICKY_EN
    assign st_a = 1'b0;
    assign st_b = 1'b0;
`endif

    logic [13:0] obs;
    assign obs = {cnt_a, wrap_a, tc_a, st_a, cnt_b, wrap_b, tc_b, st_b};

    function automatic logic [6:0] exp_one(input int i);
        logic [3:0] c;
        logic       t, s;
        c = 4'(m_cnt[i]);
        t = up_dn ? (m_cnt[i] == MAXV) : (m_cnt[i] == 0);
`ifdef MOD_COUNTER_STICKY_EN
        s = m_st[i] != 0;
`else
        s = 1'b0;
`endif
        return {c, m_wrap[i] != 0, t, s};
    endfunction

    function automatic logic [13:0] exp_all();
        return {exp_one(0), exp_one(1)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_wrap[i] = 0; m_st[i] = 0;
        end
    endtask

    task automatic model_edge(input bit e, ud, ld, input int lv, input bit sc);
        for (int i = 0; i < 2; i++) begin
            int w;
            w = 0;
            if (ld) begin
                m_cnt[i] = (lv > MAXV) ? MAXV : lv;
                m_ph[i] = 0;
            end else if (e) begin
                if (m_ph[i] == div[i] - 1) begin
                    m_ph[i] = 0;
                    if (ud) begin
                        w = (m_cnt[i] == MAXV) ? 1 : 0;
                        m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
                    end else begin
                        w = (m_cnt[i] == 0) ? 1 : 0;
                        m_cnt[i] = (m_cnt[i] + MAXV) % (MAXV + 1);
                    end
                end else m_ph[i]++;
            end
            m_wrap[i] = w;
            m_st[i] = (w != 0 || (m_st[i] != 0 && !sc)) ? 1 : 0;
        end
    endtask

    task automatic drive(input bit e, ud, ld, input int lv, input bit sc);
        en = e; up_dn = ud; load = ld; load_val = 4'(lv); sticky_clr = sc;
        @(posedge clk);
        model_edge(e, ud, ld, lv, sc);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_all()) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h", obs, exp_all());
        end
        checks++;
        if (cnt_a !== 4'd0 || tc_a !== 1'b1 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_const cnt=%0d tc=%b wrap=%b exp 0/1/0", cnt_a, tc_a, wrap_a);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) drive(1, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_all() || cnt_a !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset obs=%h exp=%h", obs, exp_all());
        end
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (cnt_a !== 4'd0 || wrap_a !== 1'b0 || obs !== exp_all()) begin
            errors++;
            $display("FAIL async_reset obs=%h exp=%h", obs, exp_all());
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        for (int k = 1; k <= 12; k++) begin
            drive(1, 1, 0, 0, 0);
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL up_wrap step%0d obs=%h exp=%h", k, obs, exp_all());
            end
            if (k == 10) begin
                checks++;
                if (cnt_a !== 4'd0 || wrap_a !== 1'b1) begin
                    errors++;
                    $display("FAIL up_wrap_pulse cnt=%0d wrap=%b exp 0/1", cnt_a, wrap_a);
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        drive(0, 0, 1, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            drive(1, 0, 0, 0, 0);
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL down_wrap step%0d obs=%h exp=%h", k, obs, exp_all());
            end
            if (k == 2) begin
                checks++;
                if (cnt_a !== 4'd9 || wrap_a !== 1'b1) begin
                    errors++;
                    $display("FAIL down_wrap_pulse cnt=%0d wrap=%b exp 9/1", cnt_a, wrap_a);
                end
            end
        end
    endtask

    task automatic test_load();
        drive(0, 1, 1, 13, 0);
        checks++;
        if (cnt_a !== 4'd9 || obs !== exp_all()) begin
            errors++;
            $display("FAIL load_clamp cnt=%0d obs=%h exp=%h", cnt_a, obs, exp_all());
        end
        drive(1, 1, 1, 0, 0);
        checks++;
        if (cnt_a !== 4'd0 || wrap_a !== 1'b0 || obs !== exp_all()) begin
            errors++;
            $display("FAIL load_priority cnt=%0d wrap=%b obs=%h exp=%h", cnt_a, wrap_a, obs, exp_all());
        end
    endtask

    task automatic test_prescaler();
        drive(0, 1, 1, 4, 0);
        for (int k = 0; k < 14; k++) begin
            drive((k < 2 || k > 6) ? 1'b1 : 1'b0, 1, 0, 0, 0);
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL presc k%0d obs=%h exp=%h", k, obs, exp_all());
            end
        end
        // 9 enabled edges since the load: three steps of the DIV=3 counter.
        checks++;
        if (cnt_b !== 4'd7) begin
            errors++;
            $display("FAIL presc_phase cnt_b=%0d exp 7", cnt_b);
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 2, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        checks++;
        if (cnt_b !== 4'd2 || obs !== exp_all()) begin
            errors++;
            $display("FAIL presc_load_phase cnt_b=%0d obs=%h exp=%h", cnt_b, obs, exp_all());
        end
        drive(1, 1, 0, 0, 0);
        checks++;
        if (cnt_b !== 4'd3 || obs !== exp_all()) begin
            errors++;
            $display("FAIL presc_after_load cnt_b=%0d obs=%h exp=%h", cnt_b, obs, exp_all());
        end
    endtask

`ifdef MOD_COUNTER_STICKY_EN
    task automatic test_sticky();
        drive(0, 1, 1, 8, 1);
        checks++;
        if (st_a !== 1'b0 || obs !== exp_all()) begin
            errors++;
            $display("FAIL sticky_clear st=%b exp 0", st_a);
        end
        for (int k = 0; k < 12; k++) drive(1, 1, 0, 0, 0);
        checks++;
        if (st_a !== 1'b1 || obs !== exp_all()) begin
            errors++;
            $display("FAIL sticky_hold st=%b obs=%h exp=%h", st_a, obs, exp_all());
        end
        drive(0, 1, 1, 9, 1);
        drive(1, 1, 0, 0, 1);
        checks++;
        if (st_a !== 1'b1 || wrap_a !== 1'b1 || obs !== exp_all()) begin
            errors++;
            $display("FAIL sticky_set_wins st=%b wrap=%b obs=%h exp=%h", st_a, wrap_a, obs, exp_all());
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 15), ($urandom_range(0, 7) == 0));
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL random k%0d obs=%h exp=%h", k, obs, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_prescaler();
`ifdef MOD_COUNTER_STICKY_EN
        test_sticky();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
